ptw_mem_bridge: RTL
===================

# ptw_mem_bridge

Adapter between the page-table walker's dmem request/response port and a single-outstanding, valid/ready memory read channel toward the L1 data cache / memory fabric. It accepts one PTE read at a time from the walker and issues it downstream with stable address. It returns the 64-bit PTE, or a one-cycle nack on error, flush or timeout, and exports a timeout event for the PMU.

## Interface
Parameters:
- ADDR_W, default SIZE_VADDR+1 (from mmu_pkg): physical PTE address width.
- TIMEOUT_CYCLES, default 255: maximum cycles spent in WAIT before the request is abandoned.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset; one clock domain, asynchronous and active-high.
- ptw_req_valid_i  in  1  walker request valid.
- ptw_req_addr_i  in  ADDR_W  PTE physical address.
- ptw_req_cmd_i  in  5  memory command; only M_XRD is supported.
- ptw_req_typ_i  in  4  access type; only MT_D is supported.
- ptw_req_kill_i  in  1  request kill qualifier.
- ptw_dmem_ready_o  out  1  bridge can accept a request.
- ptw_resp_valid_o  out  1  one-cycle response pulse.
- ptw_resp_nack_o  out  1  one-cycle nack pulse.
- ptw_resp_data_o  out  64  PTE data; meaningful only while ptw_resp_valid_o=1.
- flush_i  in  1  sfence/satp flush; invalidates any in-flight result.
- mem_req_valid_o  out  1  downstream request valid.
- mem_req_ready_i  in  1  downstream request ready.
- mem_req_addr_o  out  ADDR_W  downstream address; bits [2:0] are always 0.
- mem_rsp_valid_i  in  1  downstream response valid; no backpressure on this channel.
- mem_rsp_data_i  in  64  downstream response data.
- mem_rsp_err_i  in  1  downstream bus error.
- timeout_o  out  1  one-cycle pulse when a request is abandoned on timeout.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP, NACK, DRAIN.
- ptw_dmem_ready_o=1 only in IDLE.
- Acceptance (IDLE): the request is accepted when ptw_req_valid_i=1 and ptw_req_kill_i=0.
  - Legal request (cmd=M_XRD, typ=MT_D, addr[2:0]=0): latch the address, clear drop_q, go to ISSUE.
  - Any other valid, non-killed request: go to NACK.
  - ptw_req_kill_i=1: request ignored.
- ISSUE: mem_req_valid_o=1 and mem_req_addr_o=latched address, both held stable until mem_req_ready_i=1; then go to WAIT. The timer clears on entry to WAIT.
- WAIT: timer increments every cycle.
  - mem_rsp_valid_i=1 with mem_rsp_err_i=0 and drop_q=0: register the data, go to RESP.
  - mem_rsp_valid_i=1 with err=1, or with drop_q=1: go to NACK.
  - Timer reaches TIMEOUT_CYCLES with no response: pulse timeout_o, go to NACK, set orphan_q.
- RESP: ptw_resp_valid_o=1 with the registered data; return to IDLE.
- NACK: ptw_resp_nack_o=1; next state is DRAIN if orphan_q=1, else IDLE.
- DRAIN: ready=0; wait for the stray mem_rsp_valid_i, discard it, clear orphan_q, go to IDLE.
- flush_i in ISSUE or WAIT sets drop_q. The downstream request is never retracted once mem_req_valid_o is asserted.
- flush_i in IDLE, RESP, NACK or DRAIN has no effect.
- mem_rsp_valid_i in IDLE, ISSUE, RESP or NACK is ignored.
- Simultaneous events: if the response and the timeout limit arrive in the same WAIT cycle, the response wins. If flush_i arrives in the same cycle as the response, the result is a nack.
- Reset mid-operation: FSM goes to IDLE, all flags are cleared, and no stray response is tracked.

## Timing
- Reset values: ptw_dmem_ready_o=1; every other output 0, including ptw_resp_data_o=0. orphan_q=0, drop_q=0, timer=0.
- Acceptance in cycle T gives mem_req_valid_o=1 in T+1.
- A downstream handshake in T+j puts the FSM in WAIT from T+j+1.
- A response in cycle R gives ptw_resp_valid_o or ptw_resp_nack_o in R+1.
- Minimum latency from acceptance to response pulse: 3 cycles.
- Illegal request accepted in T: nack in T+1; ready again in T+2.
- Timeout: nack issued TIMEOUT_CYCLES+1 cycles after entering WAIT.
- Timer width is $clog2(TIMEOUT_CYCLES+1) and it saturates; it never wraps.

## Structure
- mmu_pkg: add M_XRD=5'b00000 and MT_D=4'b0011 as package constants shared with the walker.
- mmu_pkg: add a ptw_mem_req_t struct (valid, addr).
- The state enum stays local to the module.
- Single module; no sub-module needed.

## Test plan
- Legal read of addr 0x80001000, memory ready immediately, data 0x0000_0000_2000_0C01 returned after 2 cycles -> ptw_resp_valid_o pulses once, 4 cycles after acceptance, with that data; ready returns the next cycle.
- Memory holds mem_req_ready_i=0 for 5 cycles -> mem_req_addr_o stable at 0x80001000 throughout; exactly one downstream handshake.
- mem_rsp_err_i=1 on the response -> single nack pulse, no valid pulse. Separately, cmd=5'b01010 or addr=0x...004 -> nack one cycle after acceptance, and mem_req_valid_o never asserted.
- flush_i pulsed in WAIT, then a good response arrives -> nack instead of data. A subsequent request completes normally.
- TIMEOUT_CYCLES=8 with no response -> timeout_o and nack in the same cycle; ready stays 0 until the stray response arrives; that response is discarded; the next request succeeds.
- rst_i asserted while in WAIT -> all outputs return to reset values immediately (asynchronous); a stray response after reset is ignored in IDLE.

Source files
------------

// File: rtl/mmu_pkg.sv
// mmu_pkg: MMU-wide constants and types shared between the walker and its memory bridge
package mmu_pkg;
  localparam int SIZE_VADDR = 39;
  localparam logic [4:0] M_XRD = 5'b00000;
  localparam logic [3:0] MT_D = 4'b0011;
  typedef struct packed {
    logic valid;
    logic [SIZE_VADDR:0] addr;
  } ptw_mem_req_t;
endpackage

// File: rtl/ptw_mem_bridge.sv
// ptw_mem_bridge: single-outstanding PTE read adapter from the walker dmem port to a valid/ready memory channel
module ptw_mem_bridge
  import mmu_pkg::*;
#(
  parameter int ADDR_W = SIZE_VADDR + 1,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              ptw_req_valid_i,
  input  logic [ADDR_W-1:0] ptw_req_addr_i,
  input  logic [4:0]        ptw_req_cmd_i,
  input  logic [3:0]        ptw_req_typ_i,
  input  logic              ptw_req_kill_i,
  output logic              ptw_dmem_ready_o,
  output logic              ptw_resp_valid_o,
  output logic              ptw_resp_nack_o,
  output logic [63:0]       ptw_resp_data_o,
  input  logic              flush_i,
  output logic              mem_req_valid_o,
  input  logic              mem_req_ready_i,
  output logic [ADDR_W-1:0] mem_req_addr_o,
  input  logic              mem_rsp_valid_i,
  input  logic [63:0]       mem_rsp_data_i,
  input  logic              mem_rsp_err_i,
  output logic              timeout_o
);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RESP, NACK, DRAIN} state_t;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES);
  state_t state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [63:0] data_q;
  logic [TW-1:0] timer_q;
  logic drop_q, orphan_q;
  logic accept, legal, rsp_ok;
  assign accept = state_q == IDLE && ptw_req_valid_i && !ptw_req_kill_i;
  assign legal = ptw_req_cmd_i == M_XRD && ptw_req_typ_i == MT_D && ptw_req_addr_i[2:0] == 3'b000;
  // a same-cycle flush already poisons the response, so it is folded in with drop_q
  assign rsp_ok = !mem_rsp_err_i && !drop_q && !flush_i;
  // state register
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) state_q <= IDLE;
    else state_q <= state_d;
  // next-state logic; in WAIT a response takes priority over the timeout limit
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (accept) state_d = legal ? ISSUE : NACK;
      ISSUE: if (mem_req_ready_i) state_d = WAIT;
      WAIT:  if (mem_rsp_valid_i) state_d = rsp_ok ? RESP : NACK;
             else if (timer_q == TMAX) state_d = NACK;
      RESP:  state_d = IDLE;
      NACK:  state_d = orphan_q ? DRAIN : IDLE;
      DRAIN: if (mem_rsp_valid_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // outputs decoded from state and registered data only
  always_comb begin
    ptw_dmem_ready_o = state_q == IDLE;
    mem_req_valid_o = state_q == ISSUE;
    mem_req_addr_o = addr_q;
    ptw_resp_valid_o = state_q == RESP;
    ptw_resp_nack_o = state_q == NACK;
    ptw_resp_data_o = data_q;
    timeout_o = state_q == NACK && orphan_q;
  end
  // request address, response data, saturating wait timer and drop/orphan flags
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      addr_q <= '0;
      data_q <= '0;
      timer_q <= '0;
      drop_q <= 1'b0;
      orphan_q <= 1'b0;
    end else begin
      if (accept && legal) addr_q <= ptw_req_addr_i;
      if (accept && legal) drop_q <= 1'b0;
      else if ((state_q == ISSUE || state_q == WAIT) && flush_i) drop_q <= 1'b1;
      if (state_q == ISSUE && mem_req_ready_i) timer_q <= '0;
      else if (state_q == WAIT && timer_q != TMAX) timer_q <= timer_q + 1'b1;
      if (state_q == WAIT && mem_rsp_valid_i && rsp_ok) data_q <= mem_rsp_data_i;
      if (state_q == WAIT && !mem_rsp_valid_i && timer_q == TMAX) orphan_q <= 1'b1;
      else if (state_q == DRAIN && mem_rsp_valid_i) orphan_q <= 1'b0;
    end
endmodule
